lfsr_num_display: RTL
=====================

// Module: lfsr_num_display
// PURPOSE
//  Downstream consumer of the 8-bit LFSR shifter output. Watches the shifter's 8-bit value and, on every change,
//  converts it to 3-digit BCD with a sequential double-dabble FSM. Drives three registered active-low 7-segment
//  digits (decimal with leading-zero blanking, or 2-digit hex). Sits between the shifter and the board's seg pins.
// PARAMETERS
//  SHIFT_CYC   8    double-dabble iterations; equals input width, fixed at 8
//  BLANK_LZ    1    1 = blank leading zeros in decimal mode; 0 = always show three digits
// PORTS
//  clk        in   1   single clock
//  rst        in   1   synchronous, active-low reset
//  i_num      in   8   value from shifter (o_num); may change on any cycle
//  hex_mode   in   1   0 = decimal 000..255, 1 = hex 00..FF on seg1/seg0
//  bcd        out  12  {hundreds,tens,ones}, registered
//  seg0       out  8   ones/low-nibble digit, {a,b,c,d,e,f,g,dp}, active-low, dp always 1
//  seg1       out  8   tens/high-nibble digit
//  seg2       out  8   hundreds digit (always blank 8'hFF in hex mode)
//  busy       out  1   high while a conversion is in flight
//  done       out  1   one-cycle pulse in the cycle after the outputs update
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=IDLE, last_num=0, last_mode=0, pending=0, bcd=0, seg0=8'h03 ('0'),
//    seg1=seg2=8'hFF, busy=0, done=0. Reset overrides everything, including a conversion in flight.
//  - Trigger: in IDLE, (i_num!=last_num)||(hex_mode!=last_mode) -> capture both into last_*,
//    load shift reg {12'b0,i_num}, cnt=0, go SHIFT, busy=1.
//  - SHIFT: each cycle apply add-3 to every BCD nibble >=5, then shift the 20-bit reg left 1; cnt++.
//    After the 8th shift edge go LOAD.
//  - LOAD: register bcd and seg0..2 from the result and last_mode. done=1 in the next cycle. Go IDLE, busy=0.
//  - Latency: outputs update on the 10th posedge after the first edge that samples a change. The capture edge
//    is edge 1, edges 2-9 are the shifts and edge 10 is LOAD. done is high for the following cycle only.
//  - Change during SHIFT/LOAD: set pending. The in-flight conversion completes and its outputs are published.
//    IDLE then re-compares and retriggers immediately. Multiple changes collapse into one retrigger, using the
//    latest value. The last value present at IDLE is always what ends up displayed.
//  - Decimal mode: seg2/seg1/seg0 = decode(hundreds/tens/ones). With BLANK_LZ, hundreds==0 -> seg2=FF, and
//    hundreds==0&&tens==0 -> seg1=FF. Ones is never blanked.
//  - Hex mode: seg1 = decode(last_num[7:4]), seg0 = decode(last_num[3:0]), seg2=FF. bcd is still the decimal value.
//  - Width rule: BCD nibbles are 4 bits. Add-3 is done before the shift, so the result never exceeds 9 and
//    there is no carry out of hundreds (max 255).
//  - Decoder (active-low {a..g,dp}): 0=03 1=9F 2=25 3=0D 4=99 5=49 6=41 7=1F 8=01 9=09 A=11 b=C1 C=63 d=85 E=61 F=71.
//  - busy and done are never both high in the same cycle. done is never high for two consecutive cycles
//    (back-to-back retriggers take at least 10 cycles).
// STRUCTURE
//  - Header seg_defs.vh: state encodings (IDLE/SHIFT/LOAD), SEG_BLANK=8'hFF, digit pattern constants.
//  - Sub-module hex7seg: 4-bit nibble -> 8-bit active-low pattern. Combinational, instantiated 3x.
//  - Top: FSM, 4-bit shift counter, 20-bit double-dabble register, last_num/last_mode/pending, output registers.
// TESTING
//  1. Reset with i_num=0, hold 20 cycles -> bcd=0, seg0=03, seg1=seg2=FF, busy=0, done never pulses.
//  2. i_num 0->255, hex_mode=0 -> busy for 10 cycles, then bcd=12'h255, seg2=25, seg1=49, seg0=49, done 1 cycle.
//  3. i_num=9 -> seg2=FF, seg1=FF, seg0=09; BLANK_LZ=0 build -> seg2=03, seg1=03.
//  4. hex_mode=1, i_num=8'hA7 -> seg2=FF, seg1=11, seg0=1F, bcd=12'h167; toggle hex_mode only -> reconversion, decimal shown.
//  5. i_num 100 then 42 three cycles later (mid-SHIFT) -> first done shows 100 (seg2=9F,seg1=03,seg0=03),
//     second done ~10 cycles later shows 42 (seg2=FF,seg1=99,seg0=25). Exactly two done pulses.
//  6. rst low during cycle 5 of SHIFT -> next cycle all outputs at reset values, busy=0, no done. After release,
//     i_num!=0 retriggers a full conversion.

Source files
------------

// File: rtl/lfsr_num_display_pkg.sv
// Shared types and helpers for the LFSR number display: FSM states, segment
// patterns and a single double-dabble step.
`default_nettype none

package lfsr_num_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {a,b,c,d,e,f,g,dp}; dp is always off.
    localparam logic [7:0] SEG_0 = 8'h03;
    localparam logic [7:0] SEG_1 = 8'h9F;
    localparam logic [7:0] SEG_2 = 8'h25;
    localparam logic [7:0] SEG_3 = 8'h0D;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h49;
    localparam logic [7:0] SEG_6 = 8'h41;
    localparam logic [7:0] SEG_7 = 8'h1F;
    localparam logic [7:0] SEG_8 = 8'h01;
    localparam logic [7:0] SEG_9 = 8'h09;
    localparam logic [7:0] SEG_A = 8'h11;
    localparam logic [7:0] SEG_B = 8'hC1;
    localparam logic [7:0] SEG_C = 8'h63;
    localparam logic [7:0] SEG_D = 8'h85;
    localparam logic [7:0] SEG_E = 8'h61;
    localparam logic [7:0] SEG_F = 8'h71;

    function automatic logic [7:0] seg_decode(input logic [3:0] nibble);
        logic [7:0] pat;
        case (nibble)
            4'h0: pat = SEG_0;
            4'h1: pat = SEG_1;
            4'h2: pat = SEG_2;
            4'h3: pat = SEG_3;
            4'h4: pat = SEG_4;
            4'h5: pat = SEG_5;
            4'h6: pat = SEG_6;
            4'h7: pat = SEG_7;
            4'h8: pat = SEG_8;
            4'h9: pat = SEG_9;
            4'hA: pat = SEG_A;
            4'hB: pat = SEG_B;
            4'hC: pat = SEG_C;
            4'hD: pat = SEG_D;
            4'hE: pat = SEG_E;
            default: pat = SEG_F;
        endcase
        return pat;
    endfunction

    // Register layout: {hundreds[19:16], tens[15:12], ones[11:8], binary[7:0]}.
    // Add-3 precedes the shift, so no nibble can ever exceed 9 afterwards.
    function automatic logic [19:0] dabble_step(input logic [19:0] r);
        logic [19:0] a;
        a = r;
        for (int i = 0; i < 3; i++) begin
            if (a[8 + 4*i +: 4] >= 4'd5) begin
                a[8 + 4*i +: 4] = a[8 + 4*i +: 4] + 4'd3;
            end
        end
        return {a[18:0], 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_num_display_hex7seg.sv
// Combinational nibble to active-low 7-segment pattern decoder.
`default_nettype none

module lfsr_num_display_hex7seg
    import lfsr_num_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    always_comb begin
        seg = seg_decode(nibble);
    end

endmodule

`default_nettype wire

// File: rtl/lfsr_num_display.sv
// Watches the shifter value, converts each new value to BCD with a sequential
// double-dabble and drives three registered active-low 7-segment digits.
`default_nettype none

module lfsr_num_display
    import lfsr_num_display_pkg::*;
#(
    parameter int SHIFT_CYC = 8,
    parameter bit BLANK_LZ  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_num,
    input  logic        hex_mode,
    output logic [11:0] bcd,
    output logic [7:0]  seg0,
    output logic [7:0]  seg1,
    output logic [7:0]  seg2,
    output logic        busy,
    output logic        done
);

    state_t      state;
    state_t      state_next;
    logic [7:0]  last_num;
    logic        last_mode;
    logic        pending;
    logic [3:0]  cnt;
    logic [19:0] sreg;

    logic        changed;
    logic        capture;
    logic        shift_en;
    logic        load_en;

    logic [3:0]  hund;
    logic [3:0]  tens;
    logic [3:0]  ones;
    logic [3:0]  dig1;
    logic [3:0]  dig0;
    logic [7:0]  dec2;
    logic [7:0]  dec1;
    logic [7:0]  dec0;
    logic [7:0]  seg2_next;
    logic [7:0]  seg1_next;

    assign changed = (i_num != last_num) || (hex_mode != last_mode);

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        shift_en   = 1'b0;
        load_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (changed || pending) begin
                    capture    = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (cnt == 4'(SHIFT_CYC - 1)) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_en    = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign hund = sreg[19:16];
    assign tens = sreg[15:12];
    assign ones = sreg[11:8];
    assign dig1 = last_mode ? last_num[7:4] : tens;
    assign dig0 = last_mode ? last_num[3:0] : ones;

    lfsr_num_display_hex7seg u_dig2 (.nibble(hund), .seg(dec2));
    lfsr_num_display_hex7seg u_dig1 (.nibble(dig1), .seg(dec1));
    lfsr_num_display_hex7seg u_dig0 (.nibble(dig0), .seg(dec0));

    always_comb begin
        seg2_next = dec2;
        seg1_next = dec1;
        if (last_mode || (BLANK_LZ && hund == 4'd0)) begin
            seg2_next = SEG_BLANK;
        end
        if (!last_mode && BLANK_LZ && hund == 4'd0 && tens == 4'd0) begin
            seg1_next = SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_num  <= 8'd0;
            last_mode <= 1'b0;
            pending   <= 1'b0;
            cnt       <= 4'd0;
            sreg      <= 20'd0;
            bcd       <= 12'd0;
            seg0      <= SEG_0;
            seg1      <= SEG_BLANK;
            seg2      <= SEG_BLANK;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= load_en;
            if (capture) begin
                last_num  <= i_num;
                last_mode <= hex_mode;
                sreg      <= {12'd0, i_num};
                cnt       <= 4'd0;
                busy      <= 1'b1;
                pending   <= 1'b0;
            end else if (state != ST_IDLE && changed) begin
                // Remember the change; the newest value is re-captured in IDLE.
                pending <= 1'b1;
            end
            if (shift_en) begin
                sreg <= dabble_step(sreg);
                cnt  <= cnt + 4'd1;
            end
            if (load_en) begin
                bcd  <= sreg[19:8];
                seg2 <= seg2_next;
                seg1 <= seg1_next;
                seg0 <= dec0;
                busy <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
